// File: rtl/pwm_pulse_decoder.sv
// -----------------------------------------------------------------------------
// pwm_pulse_decoder
//
// Servo-style PWM receiver. Measures the high time and the rising-to-rising
// period of a pulse train on one pin, classifies the high time into the motor
// drive codes (01 fwd, 00 stop, 10 rev), flags loss of signal, and drives a
// debug nibble for a 7-segment display.
//
// Parameters
//   HI_THRESH   width (cycles) strictly above which cmd = 2'b01
//   LO_THRESH   width (cycles) strictly below which cmd = 2'b10
//   TIMEOUT     cycles of pcnt in a measurement before the signal is lost
//   FILTER_LEN  stable-sample count of the glitch filter (exists only when
//               PWM_DECODE_FILTER_EN is defined)
//
// Ports
//   m_clock   in   1   system clock
//   p_reset   in   1   synchronous, active-high reset
//   pwm_in    in   1   asynchronous PWM pin
//   width     out  31  last measured high time, cycles
//   period    out  31  last measured rising-to-rising period, cycles
//   valid     out  1   one-cycle strobe: width/period/cmd updated this cycle
//   cmd       out  2   drive code: 01 fwd, 00 stop, 10 rev (11 never driven)
//   lost      out  1   level: no completed pulse within TIMEOUT
//   HEX       out  4   {lost, 1'b0, cmd} debug nibble
//
// Build option
//   PWM_DECODE_FILTER_EN  when defined, the synchronized input only changes
//   after holding a new level for FILTER_LEN consecutive cycles (pulses
//   shorter than that are ignored; latency grows by FILTER_LEN cycles).
//
// Handshake: valid is a single-cycle strobe with no back-pressure; width,
// period and cmd are stable from the strobe until the next strobe (cmd is
// also forced to 00 on loss of signal).
// -----------------------------------------------------------------------------
module pwm_pulse_decoder #(
    parameter logic [30:0] HI_THRESH = 31'd77760,
    parameter logic [30:0] LO_THRESH = 31'd72760,
    parameter logic [30:0] TIMEOUT   = 31'd2000000
`ifdef PWM_DECODE_FILTER_EN
    ,
    parameter int          FILTER_LEN = 4
`endif
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        pwm_in,
    output logic [30:0] width,
    output logic [30:0] period,
    output logic        valid,
    output logic [1:0]  cmd,
    output logic        lost,
    output logic [3:0]  HEX
);

    localparam logic [30:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic        sync1;
    logic        sync2;
    logic        s;
    logic        s_d;
    logic        edge_en;
    logic        rise;
    logic        fall;

    state_t      state;
    state_t      state_nxt;
    logic        start;
    logic        capture;
    logic        publish;
    logic        timeout;

    logic [30:0] wcnt;
    logic [30:0] pcnt;
    logic [30:0] whold;

    // -------------------------------------------------------------------------
    // Conditioned input level s
    // -------------------------------------------------------------------------
`ifdef PWM_DECODE_FILTER_EN
    localparam int FCW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int SETTLE = 3 + FILTER_LEN;

    logic [FCW-1:0] filt_cnt;

    // s follows sync2 only once sync2 has disagreed with it for FILTER_LEN
    // consecutive samples; any return to the old level restarts the count.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            s        <= 1'b0;
            filt_cnt <= '0;
        end else if (sync2 == s) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            s        <= sync2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    localparam int SETTLE = 3;

    assign s = sync2;
`endif

    localparam int SW = $clog2(SETTLE + 1);

    logic [SW-1:0] settle;

    // The synchronizer restarts from 0 on reset, so a pin that is already
    // high would look like a fresh rising edge once it propagates through.
    // Edge detection is masked until the pipeline has refilled, so a reset
    // in the middle of a pulse never starts a measurement on a partial pulse.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            s_d    <= 1'b0;
            settle <= '0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            s_d   <= s;
            if (settle != SW'(SETTLE)) begin
                settle <= settle + 1'b1;
            end
        end
    end

    assign edge_en = (settle == SW'(SETTLE));
    assign rise    = s & ~s_d & edge_en;
    assign fall    = ~s & s_d & edge_en;

    // -------------------------------------------------------------------------
    // Measurement FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        publish   = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    start     = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (pcnt == TIMEOUT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else if (fall) begin
                    capture   = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                // A rise on the timeout cycle still completes the period.
                if (rise) begin
                    publish   = 1'b1;
                    start     = 1'b1;
                    state_nxt = HIGH;
                end else if (pcnt == TIMEOUT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    function automatic logic [1:0] classify(input logic [30:0] w);
        if (w > HI_THRESH) begin
            return 2'b01;
        end else if (w < LO_THRESH) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // -------------------------------------------------------------------------
    // Counters and published results
    // -------------------------------------------------------------------------
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            wcnt   <= '0;
            pcnt   <= '0;
            whold  <= '0;
            width  <= '0;
            period <= '0;
            valid  <= 1'b0;
            cmd    <= 2'b00;
            lost   <= 1'b1;
        end else begin
            valid <= publish;
            if (start) begin
                // The rise cycle itself is the first high cycle of the pulse.
                wcnt <= 31'd1;
                pcnt <= 31'd1;
            end else begin
                if (state == HIGH && wcnt != CNT_MAX) begin
                    wcnt <= wcnt + 31'd1;
                end
                if (state != IDLE && pcnt != CNT_MAX) begin
                    pcnt <= pcnt + 31'd1;
                end
            end
            if (capture) begin
                whold <= wcnt;
            end
            if (publish) begin
                width  <= whold;
                period <= pcnt;
                cmd    <= classify(whold);
                lost   <= 1'b0;
            end
            if (timeout) begin
                lost <= 1'b1;
                cmd  <= 2'b00;
            end
        end
    end

    assign HEX = {lost, 1'b0, cmd};

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_pulse_decoder
//
// Drives pulse trains into pwm_pulse_decoder with scaled-down thresholds and
// timeout, predicts every published measurement from the pulses it drives,
// and reports one summary line at the end.
// -----------------------------------------------------------------------------
module tb_pwm_pulse_decoder;

  localparam int HI = 100;
  localparam int LO = 80;
  localparam int TO = 600;
`ifdef PWM_DECODE_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic        m_clock = 1'b0;
  logic        p_reset = 1'b1;
  logic        pwm_in  = 1'b0;
  logic [30:0] width;
  logic [30:0] period;
  logic        valid;
  logic [1:0]  cmd;
  logic        lost;
  logic [3:0]  HEX;

  always #5 m_clock = ~m_clock;

  int unsigned cyc = 0;
  always @(posedge m_clock) cyc <= cyc + 1;

  pwm_pulse_decoder #(
    .HI_THRESH (31'(HI)),
    .LO_THRESH (31'(LO)),
    .TIMEOUT   (31'(TO))
  ) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .pwm_in  (pwm_in),
    .width   (width),
    .period  (period),
    .valid   (valid),
    .cmd     (cmd),
    .lost    (lost),
    .HEX     (HEX)
  );

  // ---------------------------------------------------------------- model state
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  logic [30:0] exp_w_q[$];
  logic [30:0] exp_p_q[$];
  logic [1:0]  exp_c_q[$];

  bit          have_prev = 1'b0;
  int          prev_hi;
  int          prev_per;
  int          last_w = 0;
  int          last_p = 0;
  int unsigned rise_cyc = 0;

  function automatic logic [1:0] classify(input int w);
    if (w > HI) return 2'b01;
    if (w < LO) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input bit ok,
                     input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (ok) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge m_clock);
  endtask

  task automatic push_exp(input int w, input int p);
    exp_w_q.push_back(31'(w));
    exp_p_q.push_back(31'(p));
    exp_c_q.push_back(classify(w));
    last_w = w;
    last_p = p;
  endtask

  // Every rising edge completes the previous pulse of the same train.
  task automatic rise_model(input int hi, input int per);
    if (have_prev) push_exp(prev_hi, prev_per);
    have_prev = 1'b1;
    prev_hi   = hi;
    prev_per  = per;
    rise_cyc  = cyc;
  endtask

  task automatic pulse(input int hi, input int per);
    rise_model(hi, per);
    pwm_in = 1'b1;
    tick(hi);
    pwm_in = 1'b0;
    tick(per - hi);
  endtask

  // Pin stays low after the last rise: lost must rise exactly when the
  // period counter of that unfinished pulse reaches TO.
  task automatic check_timeout(input int ew, input int ep);
    while (cyc < rise_cyc + LAT + TO - 1) @(negedge m_clock);
    chk("lost_before_timeout", lost === 1'b0, lost, 0);
    tick(1);
    chk("lost_at_timeout", lost === 1'b1, lost, 1);
    chk("cmd_at_timeout", cmd === 2'b00, cmd, 0);
    chk("hex_at_timeout", HEX === 4'h8, HEX, 8);
    chk("width_held", width === 31'(ew), width, ew);
    chk("period_held", period === 31'(ep), period, ep);
    chk("valid_at_timeout", valid === 1'b0, valid, 0);
    have_prev = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_width"}, width === 31'd0, width, 0);
    chk({tag, "_period"}, period === 31'd0, period, 0);
    chk({tag, "_valid"}, valid === 1'b0, valid, 0);
    chk({tag, "_cmd"}, cmd === 2'b00, cmd, 0);
    chk({tag, "_lost"}, lost === 1'b1, lost, 1);
    chk({tag, "_hex"}, HEX === 4'h8, HEX, 8);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [30:0] mw;
  logic [30:0] mp;
  logic [1:0]  mc;
  logic [3:0]  mh;

  always @(negedge m_clock) begin
    if (!p_reset && valid) begin
      chk("valid_expected", exp_w_q.size() > 0, exp_w_q.size(), 1);
      if (exp_w_q.size() > 0) begin
        mw = exp_w_q.pop_front();
        mp = exp_p_q.pop_front();
        mc = exp_c_q.pop_front();
        mh = {2'b00, mc};
        chk("width", width === mw, width, mw);
        chk("period", period === mp, period, mp);
        chk("cmd", cmd === mc, cmd, mc);
        chk("lost_at_valid", lost === 1'b0, lost, 0);
        chk("hex_at_valid", HEX === mh, HEX, mh);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- directed steps
  initial begin
    int hi;
    int per;

    // Reset state.
    tick(3);
    check_reset_values("reset");
    p_reset = 1'b0;

    // Pin stuck high from reset: no measurement, lost stays set.
    pwm_in = 1'b1;
    tick(2 * TO + 100);
    chk("stuck_lost", lost === 1'b1, lost, 1);
    chk("stuck_cmd", cmd === 2'b00, cmd, 0);
    chk("stuck_width", width === 31'd0, width, 0);
    pwm_in = 1'b0;
    tick(20);
    have_prev = 1'b0;

    // Forward train; first valid at the second rise, LAT edges late.
    pulse(120, 400);
    rise_model(120, 400);
    pwm_in = 1'b1;
    tick(LAT - 1);
    chk("latency_valid_early", valid === 1'b0, valid, 0);
    chk("latency_lost_early", lost === 1'b1, lost, 1);
    tick(1);
    chk("latency_valid_on_time", valid === 1'b1, valid, 1);
    tick(120 - LAT);
    chk("fwd_hex", HEX === 4'h1, HEX, 1);
    chk("fwd_lost", lost === 1'b0, lost, 0);
    pwm_in = 1'b0;
    tick(280);
    pulse(120, 400);

    // Classification, both exclusive thresholds, rise-on-timeout.
    pulse(90, 300);
    pulse(60, 300);
    pulse(HI, 300);
    pulse(LO, 300);
    pulse(HI + 1, 300);
    pulse(LO - 1, TO);
    pulse(90, 300);
    chk("rise_wins_lost", lost === 1'b0, lost, 0);
    pulse(70, 250);
    check_timeout(last_w, last_p);

    // Random train.
    for (int i = 0; i < 30; i++) begin
      hi  = int'($urandom_range(60, 130));
      per = hi + int'($urandom_range(10, 150));
      pulse(hi, per);
    end
    check_timeout(last_w, last_p);

    // Reset in the middle of a high phase.
    pulse(110, 300);
    pulse(110, 300);
    rise_model(110, 300);
    pwm_in = 1'b1;
    tick(LAT + 20);
    p_reset = 1'b1;
    tick(1);
    check_reset_values("midreset");
    p_reset = 1'b0;
    tick(110 - LAT - 21);
    pwm_in = 1'b0;
    tick(190);
    have_prev = 1'b0;
    pulse(95, 300);
    chk("after_reset_lost", lost === 1'b1, lost, 1);
    pulse(105, 300);
    check_timeout(95, 300);

    // Two-cycle low glitch inside a 120-cycle pulse.
`ifdef PWM_DECODE_FILTER_EN
    rise_model(120, 200);
`else
    rise_model(50, 52);
`endif
    pwm_in = 1'b1;
    tick(50);
    pwm_in = 1'b0;
    tick(2);
`ifndef PWM_DECODE_FILTER_EN
    rise_model(68, 148);
`endif
    pwm_in = 1'b1;
    tick(68);
    pwm_in = 1'b0;
    tick(80);
    pulse(100, 200);
    pulse(100, 200);
    tick(LAT + 5);

    chk("exp_queue_drained", exp_w_q.size() == 0, exp_w_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
